// File: rtl/boreal_gate_monitor.sv
// -----------------------------------------------------------------------------
// boreal_gate_monitor
// Passive rule checker for NCH gate FSM channels. Each cycle it evaluates five
// rules per enabled channel and records the results one clock later.
//   R0 COMMIT reached while uncommitted with a privilege request pending
//   R1 nonce went backwards relative to the previous cycle
//   R2 LEDGER state without ledger write enable
//   R3 RESPOND state without actuator ready
//   R4 illegal state transition (history-based)
// Results are sticky per channel/rule, counted (saturating), and the first
// violation (lowest channel, then lowest rule) is captured.
//
// Configuration macro: BOREAL_MON_NONCE_WRAP_EN
//   defined   -> a nonce step from all-ones to zero is a legal wrap (no R1)
//   undefined -> that step raises R1 like any other decrease
//
// Ports
//   clk             in   sole clock, rising edge
//   rst             in   asynchronous active-high reset
//   mon_en          in   [NCH]          per-channel monitor enable
//   mon_state       in   [NCH*3]        gate state, channel c at [3c+2:3c]
//   mon_committed   in   [NCH]          gate committed flag
//   mon_priv_req    in   [NCH]          privilege request
//   mon_ledger_wr_en in  [NCH]          ledger write enable
//   mon_act_ready   in   [NCH]          actuator ready
//   mon_nonce       in   [NCH*NONCE_W]  per-channel nonce counter
//   clr             in   synchronous clear of recorded results
//   viol_sticky     out  [NCH*5]        sticky flags, channel c at [5c+4:5c]
//   viol_count      out  [CNT_W]        saturating count of violating cycles
//   first_valid     out  first violation captured
//   first_ch        out  [4]            channel of first violation
//   first_rule      out  [3]            rule of first violation
//   irq             out  registered OR of viol_sticky
// -----------------------------------------------------------------------------
module boreal_gate_monitor #(
    parameter int NCH     = 4,
    parameter int NONCE_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         mon_en,
    input  logic [NCH*3-1:0]       mon_state,
    input  logic [NCH-1:0]         mon_committed,
    input  logic [NCH-1:0]         mon_priv_req,
    input  logic [NCH-1:0]         mon_ledger_wr_en,
    input  logic [NCH-1:0]         mon_act_ready,
    input  logic [NCH*NONCE_W-1:0] mon_nonce,
    input  logic                   clr,
    output logic [NCH*5-1:0]       viol_sticky,
    output logic [CNT_W-1:0]       viol_count,
    output logic                   first_valid,
    output logic [3:0]             first_ch,
    output logic [2:0]             first_rule,
    output logic                   irq
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_CLAMP   = 3'd2,
        ST_COMMIT  = 3'd3,
        ST_LEDGER  = 3'd4,
        ST_RESPOND = 3'd5
    } gate_state_e;

    // Legal transition table; encodings 6/7 never appear in a legal pair.
    function automatic logic trans_legal(input logic [2:0] prev_st, input logic [2:0] cur_st);
        logic legal;
        case (prev_st)
            ST_IDLE:    legal = (cur_st == ST_IDLE)   || (cur_st == ST_CHECK);
            ST_CHECK:   legal = (cur_st == ST_CHECK)  || (cur_st == ST_CLAMP) || (cur_st == ST_COMMIT);
            ST_CLAMP:   legal = (cur_st == ST_CLAMP)  || (cur_st == ST_COMMIT);
            ST_COMMIT:  legal = (cur_st == ST_LEDGER) || (cur_st == ST_RESPOND);
            ST_LEDGER:  legal = (cur_st == ST_RESPOND);
            ST_RESPOND: legal = (cur_st == ST_IDLE);
            default:    legal = 1'b0;
        endcase
        return legal;
    endfunction

    logic [NCH*5-1:0] fire_s;

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_ch
            logic [2:0]         cur_st_s;
            logic [NONCE_W-1:0] cur_nonce_s;
            logic               nonce_dec_s;
            logic               past_valid_q;
            logic [2:0]         prev_state_q;
            logic [NONCE_W-1:0] prev_nonce_q;

            assign cur_st_s    = mon_state[3*g +: 3];
            assign cur_nonce_s = mon_nonce[NONCE_W*g +: NONCE_W];

`ifdef BOREAL_MON_NONCE_WRAP_EN
            // An all-ones to zero step is the counter wrapping, not a rollback.
            assign nonce_dec_s = (cur_nonce_s < prev_nonce_q) &&
                                 !((&prev_nonce_q) && (cur_nonce_s == '0));
`else
            assign nonce_dec_s = (cur_nonce_s < prev_nonce_q);
`endif

            assign fire_s[5*g + 0] = mon_en[g] && (cur_st_s == ST_COMMIT) &&
                                     !mon_committed[g] && mon_priv_req[g];
            assign fire_s[5*g + 1] = mon_en[g] && past_valid_q && nonce_dec_s;
            assign fire_s[5*g + 2] = mon_en[g] && (cur_st_s == ST_LEDGER) && !mon_ledger_wr_en[g];
            assign fire_s[5*g + 3] = mon_en[g] && (cur_st_s == ST_RESPOND) && !mon_act_ready[g];
            assign fire_s[5*g + 4] = mon_en[g] && past_valid_q &&
                                     !trans_legal(prev_state_q, cur_st_s);

            // Per-channel history; history is only trusted after one enabled cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    past_valid_q <= 1'b0;
                    prev_state_q <= ST_IDLE;
                    prev_nonce_q <= '0;
                end else begin
                    past_valid_q <= mon_en[g];
                    prev_state_q <= cur_st_s;
                    prev_nonce_q <= cur_nonce_s;
                end
            end
        end
    endgenerate

    logic [NCH*5-1:0] sticky_q, sticky_d;
    logic [CNT_W-1:0] count_q, count_d, count_base_s;
    logic             first_valid_q, first_valid_d;
    logic [3:0]       first_ch_q, first_ch_d, sel_ch_s;
    logic [2:0]       first_rule_q, first_rule_d, sel_rule_s;
    logic             irq_q, irq_d;
    logic             any_fire_s;

    // Result update: clear first, then layer this cycle's violations on top.
    always_comb begin
        any_fire_s   = |fire_s;
        sticky_d     = (clr ? '0 : sticky_q) | fire_s;
        count_base_s = clr ? '0 : count_q;
        if (any_fire_s && (count_base_s != {CNT_W{1'b1}})) begin
            count_d = count_base_s + CNT_W'(1);
        end else begin
            count_d = count_base_s;
        end

        // Scan from the top so the lowest channel/rule is the last one written.
        sel_ch_s   = 4'd0;
        sel_rule_s = 3'd0;
        for (int c = NCH - 1; c >= 0; c--) begin
            for (int r = 4; r >= 0; r--) begin
                sel_ch_s   = fire_s[5*c + r] ? c[3:0] : sel_ch_s;
                sel_rule_s = fire_s[5*c + r] ? r[2:0] : sel_rule_s;
            end
        end

        if (!(clr ? 1'b0 : first_valid_q) && any_fire_s) begin
            first_valid_d = 1'b1;
            first_ch_d    = sel_ch_s;
            first_rule_d  = sel_rule_s;
        end else if (clr) begin
            first_valid_d = 1'b0;
            first_ch_d    = 4'd0;
            first_rule_d  = 3'd0;
        end else begin
            first_valid_d = first_valid_q;
            first_ch_d    = first_ch_q;
            first_rule_d  = first_rule_q;
        end

        irq_d = |sticky_d;
    end

    // Result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q      <= '0;
            count_q       <= '0;
            first_valid_q <= 1'b0;
            first_ch_q    <= 4'd0;
            first_rule_q  <= 3'd0;
            irq_q         <= 1'b0;
        end else begin
            sticky_q      <= sticky_d;
            count_q       <= count_d;
            first_valid_q <= first_valid_d;
            first_ch_q    <= first_ch_d;
            first_rule_q  <= first_rule_d;
            irq_q         <= irq_d;
        end
    end

    assign viol_sticky = sticky_q;
    assign viol_count  = count_q;
    assign first_valid = first_valid_q;
    assign first_ch    = first_ch_q;
    assign first_rule  = first_rule_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_boreal_gate_monitor.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for boreal_gate_monitor (default parameters).
// Inputs change one ns after a rising edge; outputs are checked one ns after
// the edge that registers them.
// -----------------------------------------------------------------------------
module tb_boreal_gate_monitor;

    localparam int NCH     = 4;
    localparam int NONCE_W = 32;
    localparam int CNT_W   = 16;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CLAMP   = 3'd2;
    localparam logic [2:0] COMMIT  = 3'd3;
    localparam logic [2:0] LEDGER  = 3'd4;
    localparam logic [2:0] RESPOND = 3'd5;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NCH-1:0]         mon_en;
    logic [NCH*3-1:0]       mon_state;
    logic [NCH-1:0]         mon_committed;
    logic [NCH-1:0]         mon_priv_req;
    logic [NCH-1:0]         mon_ledger_wr_en;
    logic [NCH-1:0]         mon_act_ready;
    logic [NCH*NONCE_W-1:0] mon_nonce;
    logic                   clr;
    logic [NCH*5-1:0]       viol_sticky;
    logic [CNT_W-1:0]       viol_count;
    logic                   first_valid;
    logic [3:0]             first_ch;
    logic [2:0]             first_rule;
    logic                   irq;

    int total = 0;
    int bad   = 0;

    boreal_gate_monitor #(.NCH(NCH), .NONCE_W(NONCE_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .mon_en(mon_en), .mon_state(mon_state),
        .mon_committed(mon_committed), .mon_priv_req(mon_priv_req),
        .mon_ledger_wr_en(mon_ledger_wr_en), .mon_act_ready(mon_act_ready),
        .mon_nonce(mon_nonce), .clr(clr), .viol_sticky(viol_sticky),
        .viol_count(viol_count), .first_valid(first_valid), .first_ch(first_ch),
        .first_rule(first_rule), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mon_en = '0; mon_state = '0; mon_committed = '0; mon_priv_req = '0;
        mon_ledger_wr_en = '0; mon_act_ready = '0; mon_nonce = '0; clr = 1'b0;
    endtask

    task automatic set_ch(input int c, input logic en, input logic [2:0] st, input logic cm,
                          input logic pr, input logic lw, input logic ar, input logic [31:0] n);
        mon_en[c] = en;
        mon_state[3*c +: 3] = st;
        mon_committed[c] = cm;
        mon_priv_req[c] = pr;
        mon_ledger_wr_en[c] = lw;
        mon_act_ready[c] = ar;
        mon_nonce[NONCE_W*c +: NONCE_W] = n;
    endtask

    task automatic do_clr();
        idle_inputs();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (viol_sticky !== 20'h00000) begin bad++; $display("FAIL reset_sticky got=%h exp=%h", viol_sticky, 20'h00000); end
        total++; if (viol_count !== 16'h0000) begin bad++; $display("FAIL reset_count got=%h exp=%h", viol_count, 16'h0000); end
        total++; if ({first_valid, first_ch, first_rule} !== 8'h00) begin bad++; $display("FAIL reset_first got=%h exp=%h", {first_valid, first_ch, first_rule}, 8'h00); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=%b", irq, 1'b0); end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_r0();
        set_ch(0, 1'b1, COMMIT, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        total++; if (viol_sticky !== 20'h00001) begin bad++; $display("FAIL r0_sticky got=%h exp=%h", viol_sticky, 20'h00001); end
        total++; if (viol_count !== 16'h0001) begin bad++; $display("FAIL r0_count got=%h exp=%h", viol_count, 16'h0001); end
        total++; if ({first_valid, first_ch, first_rule} !== {1'b1, 4'd0, 3'd0}) begin bad++; $display("FAIL r0_first got=%h exp=%h", {first_valid, first_ch, first_rule}, {1'b1, 4'd0, 3'd0}); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL r0_irq got=%b exp=%b", irq, 1'b1); end
        do_clr();
        total++; if ({viol_sticky, viol_count, first_valid, irq} !== 38'h0) begin bad++; $display("FAIL clr_all got=%h exp=%h", {viol_sticky, viol_count, first_valid, irq}, 38'h0); end
    endtask

    task automatic test_nonce_decrease();
        set_ch(2, 1'b1, IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10);
        step();
        set_ch(2, 1'b1, IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20);
        step();
        total++; if (viol_sticky !== 20'h00000) begin bad++; $display("FAIL r1_increase got=%h exp=%h", viol_sticky, 20'h00000); end
        set_ch(2, 1'b1, IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0F);
        step();
        total++; if (viol_sticky !== 20'h00800) begin bad++; $display("FAIL r1_sticky got=%h exp=%h", viol_sticky, 20'h00800); end
        total++; if ({first_valid, first_ch, first_rule} !== {1'b1, 4'd2, 3'd1}) begin bad++; $display("FAIL r1_first got=%h exp=%h", {first_valid, first_ch, first_rule}, {1'b1, 4'd2, 3'd1}); end
        do_clr();
    endtask

    task automatic test_nonce_wrap();
        logic [19:0] exp_sticky;
        logic [15:0] exp_count;
`ifdef BOREAL_MON_NONCE_WRAP_EN
        exp_sticky = 20'h00000; exp_count = 16'h0000;
`else
        exp_sticky = 20'h00040; exp_count = 16'h0001;
`endif
        set_ch(1, 1'b1, IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        step();
        set_ch(1, 1'b1, IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        total++; if (viol_sticky !== exp_sticky) begin bad++; $display("FAIL wrap_sticky got=%h exp=%h", viol_sticky, exp_sticky); end
        total++; if (viol_count !== exp_count) begin bad++; $display("FAIL wrap_count got=%h exp=%h", viol_count, exp_count); end
        do_clr();
    endtask

    task automatic test_same_cycle();
        set_ch(1, 1'b1, IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        set_ch(1, 1'b1, CLAMP, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        set_ch(3, 1'b1, LEDGER, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        total++; if (viol_sticky !== 20'h20200) begin bad++; $display("FAIL same_sticky got=%h exp=%h", viol_sticky, 20'h20200); end
        total++; if (viol_count !== 16'h0001) begin bad++; $display("FAIL same_count got=%h exp=%h", viol_count, 16'h0001); end
        total++; if ({first_valid, first_ch, first_rule} !== {1'b1, 4'd1, 3'd4}) begin bad++; $display("FAIL same_first got=%h exp=%h", {first_valid, first_ch, first_rule}, {1'b1, 4'd1, 3'd4}); end
        idle_inputs();
        set_ch(0, 1'b1, COMMIT, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        total++; if (viol_count !== 16'h0002) begin bad++; $display("FAIL later_count got=%h exp=%h", viol_count, 16'h0002); end
        total++; if ({first_valid, first_ch, first_rule} !== {1'b1, 4'd1, 3'd4}) begin bad++; $display("FAIL first_hold got=%h exp=%h", {first_valid, first_ch, first_rule}, {1'b1, 4'd1, 3'd4}); end
        total++; if (viol_sticky !== 20'h20201) begin bad++; $display("FAIL later_sticky got=%h exp=%h", viol_sticky, 20'h20201); end
    endtask

    task automatic test_clr_with_viol();
        do_clr();
        set_ch(0, 1'b1, IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        set_ch(2, 1'b1, COMMIT, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        total++; if (viol_sticky !== 20'h00400) begin bad++; $display("FAIL pre_clr_sticky got=%h exp=%h", viol_sticky, 20'h00400); end
        idle_inputs();
        set_ch(0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        total++; if (viol_sticky !== 20'h00010) begin bad++; $display("FAIL clrv_sticky got=%h exp=%h", viol_sticky, 20'h00010); end
        total++; if (viol_count !== 16'h0001) begin bad++; $display("FAIL clrv_count got=%h exp=%h", viol_count, 16'h0001); end
        total++; if ({first_valid, first_ch, first_rule} !== {1'b1, 4'd0, 3'd4}) begin bad++; $display("FAIL clrv_first got=%h exp=%h", {first_valid, first_ch, first_rule}, {1'b1, 4'd0, 3'd4}); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL clrv_irq got=%b exp=%b", irq, 1'b1); end
    endtask

    task automatic test_saturate();
        do_clr();
        set_ch(0, 1'b1, COMMIT, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (65534) @(posedge clk);
        #1;
        total++; if (viol_count !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h exp=%h", viol_count, 16'hFFFE); end
        step();
        total++; if (viol_count !== 16'hFFFF) begin bad++; $display("FAIL sat_reach got=%h exp=%h", viol_count, 16'hFFFF); end
        step();
        step();
        total++; if (viol_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=%h", viol_count, 16'hFFFF); end
        total++; if (viol_sticky !== 20'h00011) begin bad++; $display("FAIL sat_sticky got=%h exp=%h", viol_sticky, 20'h00011); end
    endtask

    task automatic test_rst_mid();
        idle_inputs();
        set_ch(1, 1'b1, IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h50);
        step();
        rst = 1'b1;
        #2;
        total++; if (viol_sticky !== 20'h00000) begin bad++; $display("FAIL rst_sticky got=%h exp=%h", viol_sticky, 20'h00000); end
        total++; if (viol_count !== 16'h0000) begin bad++; $display("FAIL rst_count got=%h exp=%h", viol_count, 16'h0000); end
        total++; if ({first_valid, first_ch, first_rule, irq} !== 9'h000) begin bad++; $display("FAIL rst_first_irq got=%h exp=%h", {first_valid, first_ch, first_rule, irq}, 9'h000); end
        @(negedge clk);
        rst = 1'b0;
        // IDLE->RESPOND and a nonce drop would both fire if history survived.
        set_ch(1, 1'b1, RESPOND, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10);
        step();
        total++; if ({viol_sticky, viol_count} !== 36'h0) begin bad++; $display("FAIL post_rst_first got=%h exp=%h", {viol_sticky, viol_count}, 36'h0); end
        set_ch(1, 1'b1, IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h11);
        step();
        total++; if ({viol_sticky, viol_count} !== 36'h0) begin bad++; $display("FAIL post_rst_legal got=%h exp=%h", {viol_sticky, viol_count}, 36'h0); end
        set_ch(1, 1'b1, COMMIT, 1'b1, 1'b0, 1'b0, 1'b0, 32'h12);
        step();
        total++; if (viol_sticky !== 20'h00200) begin bad++; $display("FAIL post_rst_r4 got=%h exp=%h", viol_sticky, 20'h00200); end
        total++; if ({first_valid, first_ch, first_rule} !== {1'b1, 4'd1, 3'd4}) begin bad++; $display("FAIL post_rst_first_cap got=%h exp=%h", {first_valid, first_ch, first_rule}, {1'b1, 4'd1, 3'd4}); end
    endtask

    initial begin
        test_reset();
        test_r0();
        test_nonce_decrease();
        test_nonce_wrap();
        test_same_cycle();
        test_clr_with_viol();
        test_saturate();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
